// File: rtl/mips_defs.sv
// mips_defs
// Shared definitions for the MIPS pipeline hazard logic.
//   - Forwarding-select encodings driven onto forwardaE / forwardbE.
//   - Divider sequencer state encoding.
//   - regMatch(): register comparison that never matches register 0,
//     since $zero is hardwired and can never carry a real dependency.
package mips_defs;

   // E-stage operand source selects
   localparam logic [1:0] FWD_NONE = 2'b00;  // register file
   localparam logic [1:0] FWD_W    = 2'b01;  // write-back result
   localparam logic [1:0] FWD_M    = 2'b10;  // memory-stage ALU result

   // Divider sequencer states
   typedef enum logic [1:0] {
      DivIdle = 2'b00,
      DivBusy = 2'b01,
      DivDone = 2'b10
   } divState_t;

   // True when a names a real register and equals b.
   function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage

// File: rtl/div_sequencer.sv
// div_sequencer
// Tracks a multi-cycle divide occupying the E stage so the pipeline holds E
// until the HI/LO result is available.
//
// Parameters:
//   DIV_CYCLES  cycles the divider needs after issue (legal 2..64)
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   divstartE  in   divide instruction occupies E
//   divstall   out  hold E (and everything upstream) for the divide
//   divbusy    out  sequencer not idle
//   divdoneE   out  one-cycle pulse, HI/LO write permitted
//
// A divide first seen in E in cycle t stalls t..t+DIV_CYCLES and pulses
// divdoneE in t+DIV_CYCLES+1, after which the instruction leaves E.
module div_sequencer
   import mips_defs::*;
#(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic divstartE,
   output logic divstall,
   output logic divbusy,
   output logic divdoneE
);

   localparam logic [5:0] CountLoad = 6'(DIV_CYCLES - 1);

   divState_t  state, stateNext;
   logic [5:0] count, countNext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DivIdle;
         count <= 6'd0;
      end else begin
         state <= stateNext;
         count <= countNext;
      end
   end

   always_comb begin
      stateNext = state;
      countNext = count;
      unique case (state)
         DivIdle: begin
            if (divstartE) begin
               stateNext = DivBusy;
               countNext = CountLoad;
            end
         end
         DivBusy: begin
            if (count == 6'd0) begin
               stateNext = DivDone;
            end else begin
               countNext = count - 6'd1;
            end
         end
         // Always return to idle, even with divstartE still high: the
         // finishing divide leaves E at the end of this cycle, so a
         // following divide is only seen from the next cycle onward.
         DivDone: stateNext = DivIdle;
         default: stateNext = DivIdle;
      endcase
   end

   // The idle-state term makes the stall start in the very cycle the divide
   // appears in E. Gating with rst drops the stall immediately on a reset
   // even when divstartE is still asserted.
   assign divstall = ~rst & (((state == DivIdle) & divstartE) | (state == DivBusy));
   assign divbusy  = (state != DivIdle);
   assign divdoneE = (state == DivDone);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard detection, stall/flush generation and forwarding selects for the
// five-stage MIPS pipeline.
//
// Parameters:
//   DIV_CYCLES  divider latency after issue (legal 2..64)
// Ports:
//   clk, rst                           clock, async active-high reset
//   rsD, rtD                      in   decode-stage sources
//   rsE, rtE                      in   execute-stage sources
//   writeregE/M/W                 in   per-stage destination register
//   branchD                       in   branch compare in decode
//   regwriteE/M/W                 in   per-stage register write enables
//   memtoregE/M                   in   load in E / M
//   divstartE                     in   divide occupies E
//   memreqM, memreadyM            in   data-memory request / ready
//   forwardaD, forwardbD          out  M ALU result into the D comparator
//   forwardaE, forwardbE          out  E operand select (mips_defs FWD_*)
//   stallF/D/E/M/W                out  hold pipeline registers
//   flushE/M/W                    out  bubble into that stage's register
//   divbusy, divdoneE             out  divider sequencer status
//
// Everything except the divider state is combinational from the inputs.
module hazard_unit
   import mips_defs::*;
#(
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic [4:0] rsE,
   input  logic [4:0] rtE,
   input  logic [4:0] writeregE,
   input  logic [4:0] writeregM,
   input  logic [4:0] writeregW,
   input  logic       branchD,
   input  logic       regwriteE,
   input  logic       regwriteM,
   input  logic       regwriteW,
   input  logic       memtoregE,
   input  logic       memtoregM,
   input  logic       divstartE,
   input  logic       memreqM,
   input  logic       memreadyM,
   output logic       forwardaD,
   output logic       forwardbD,
   output logic [1:0] forwardaE,
   output logic [1:0] forwardbE,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       stallM,
   output logic       stallW,
   output logic       flushE,
   output logic       flushM,
   output logic       flushW,
   output logic       divbusy,
   output logic       divdoneE
);

   logic lwstall;
   logic branchstall;
   logic memstall;
   logic divstall;

   div_sequencer #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_divSeq (
      .clk       (clk),
      .rst       (rst),
      .divstartE (divstartE),
      .divstall  (divstall),
      .divbusy   (divbusy),
      .divdoneE  (divdoneE)
   );

   // E-stage forwarding: the younger M result has priority over W.
   always_comb begin
      forwardaE = FWD_NONE;
      if (regwriteM && regMatch(rsE, writeregM)) begin
         forwardaE = FWD_M;
      end else if (regwriteW && regMatch(rsE, writeregW)) begin
         forwardaE = FWD_W;
      end

      forwardbE = FWD_NONE;
      if (regwriteM && regMatch(rtE, writeregM)) begin
         forwardbE = FWD_M;
      end else if (regwriteW && regMatch(rtE, writeregW)) begin
         forwardbE = FWD_W;
      end
   end

   // D-stage comparator can only take the M-stage ALU result.
   assign forwardaD = regwriteM & regMatch(rsD, writeregM);
   assign forwardbD = regwriteM & regMatch(rtD, writeregM);

   // Load in E whose data a D-stage instruction needs next cycle.
   assign lwstall = memtoregE & (regMatch(rtE, rsD) | regMatch(rtE, rtD));

   // Branch compares in D: an ALU result still in E, or load data still in M,
   // is not yet available for forwarding.
   always_comb begin
      branchstall = 1'b0;
      if (branchD) begin
         if (regwriteE && (regMatch(writeregE, rsD) || regMatch(writeregE, rtD))) begin
            branchstall = 1'b1;
         end
         if (memtoregM && (regMatch(writeregM, rsD) || regMatch(writeregM, rtD))) begin
            branchstall = 1'b1;
         end
      end
   end

   assign memstall = memreqM & ~memreadyM;

   assign stallF = lwstall | branchstall | divstall | memstall;
   assign stallD = stallF;
   assign stallE = divstall | memstall;
   assign stallM = memstall;
   assign stallW = 1'b0;

   // A held E register must keep its instruction, so no bubble while stalled.
   assign flushE = (lwstall | branchstall) & ~stallE;
   // While E holds a divide, M receives bubbles unless M itself is held.
   assign flushM = divstall & ~memstall;
   // M is held on a memory wait; W must not re-retire its instruction.
   assign flushW = memstall;

endmodule
